// File: rtl/imuldiv_div_issue_unit_pkg.sv
// Shared encodings for the divide issue unit: divider fn codes, the
// quotient/remainder select, result field positions and stage states.
package imuldiv_div_issue_unit_pkg;

   localparam logic DIVREQ_MSG_FN_SIGNED   = 1'b0;
   localparam logic DIVREQ_MSG_FN_UNSIGNED = 1'b1;

   localparam logic SEL_QUOT = 1'b0;
   localparam logic SEL_REM  = 1'b1;

   localparam int QUOT_LSB = 0;
   localparam int QUOT_MSB = 31;
   localparam int REM_LSB  = 32;
   localparam int REM_MSB  = 63;

   localparam logic [0:0] ST_EMPTY = 1'b0;
   localparam logic [0:0] ST_FULL  = 1'b1;

   typedef struct packed {
      logic        fn;
      logic [31:0] a;
      logic [31:0] b;
      logic        sel;
   } div_op_t;

   function automatic logic [31:0] select_result(input logic sel, input logic [63:0] result);
      return (sel == SEL_REM) ? result[REM_MSB:REM_LSB] : result[QUOT_MSB:QUOT_LSB];
   endfunction

endpackage

// File: rtl/imuldiv_DivTagQueue.sv
// In-order FIFO of {sel,tag} for outstanding divreqs. Pointers wrap
// naturally because DEPTH is a power of two.
module imuldiv_DivTagQueue
#(
   parameter int DEPTH = 4,
   parameter int W     = 6
)(
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] pop_data,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE = 1;
   localparam logic [AW:0]   CNT_ONE = 1;
   localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] head;
   logic [AW-1:0] tail;
   logic [AW:0]   count;
   logic          do_push;
   logic          do_pop;

   // A full queue refuses pushes even when a pop frees a slot this cycle.
   assign full     = (count == CNT_MAX);
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[head];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[tail] <= push_data;
            tail      <= tail + PTR_ONE;
         end
         if (do_pop) head <= head + PTR_ONE;
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/imuldiv_div_issue_unit.sv
// Issues divide ops to the iterative divider and returns the selected
// quotient/remainder with its destination tag, in request order.
module imuldiv_div_issue_unit
   import imuldiv_div_issue_unit_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int TAGW  = 5
)(
   input  logic            clk,
   input  logic            reset,
   input  logic            op_val,
   output logic            op_rdy,
   input  logic            op_fn,
   input  logic            op_sel,
   input  logic [31:0]     op_a,
   input  logic [31:0]     op_b,
   input  logic [TAGW-1:0] op_tag,
   output logic            divreq_msg_fn,
   output logic [31:0]     divreq_msg_a,
   output logic [31:0]     divreq_msg_b,
   output logic            divreq_val,
   input  logic            divreq_rdy,
   input  logic [63:0]     divresp_msg_result,
   input  logic            divresp_val,
   output logic            divresp_rdy,
   output logic            wb_val,
   input  logic            wb_rdy,
   output logic [31:0]     wb_data,
   output logic [TAGW-1:0] wb_tag,
   output logic            err
);

   localparam int QW = TAGW + 1;

   logic [0:0]      req_state;
   div_op_t         req_op;
   logic [TAGW-1:0] req_tag;
   logic [0:0]      wb_state;

   logic            op_fire;
   logic            req_fire;
   logic            resp_fire;
   logic            wb_fire;
   logic            q_full;
   logic            q_empty;
   logic [QW-1:0]   q_head;
   logic            head_sel;
   logic [TAGW-1:0] head_tag;

   // Every channel transfers on a cycle where val && rdy at the rising edge;
   // val never waits on rdy, rdy may look at the downstream fire.
   assign divreq_val  = (req_state == ST_FULL) && !q_full;
   assign req_fire    = divreq_val && divreq_rdy;
   assign op_rdy      = (req_state == ST_EMPTY) || req_fire;
   assign op_fire     = op_val && op_rdy;

   assign wb_val      = (wb_state == ST_FULL);
   assign wb_fire     = wb_val && wb_rdy;
   assign divresp_rdy = !q_empty && (!wb_val || wb_fire);
   assign resp_fire   = divresp_val && divresp_rdy;

   assign divreq_msg_fn = req_op.fn;
   assign divreq_msg_a  = req_op.a;
   assign divreq_msg_b  = req_op.b;

   assign {head_sel, head_tag} = q_head;

   imuldiv_DivTagQueue #(.DEPTH(DEPTH), .W(QW)) tag_q (
      .clk       (clk),
      .reset     (reset),
      .push      (req_fire),
      .push_data ({req_op.sel, req_tag}),
      .pop       (resp_fire),
      .pop_data  (q_head),
      .full      (q_full),
      .empty     (q_empty)
   );

   // A new op may land in the same cycle the held op issues.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         req_state <= ST_EMPTY;
         req_op    <= '0;
         req_tag   <= '0;
      end else if (op_fire) begin
         req_state <= ST_FULL;
         req_op    <= '{fn: op_fn, a: op_a, b: op_b, sel: op_sel};
         req_tag   <= op_tag;
      end else if (req_fire) begin
         req_state <= ST_EMPTY;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wb_state <= ST_EMPTY;
         wb_data  <= '0;
         wb_tag   <= '0;
      end else if (resp_fire) begin
         wb_state <= ST_FULL;
         wb_data  <= select_result(head_sel, divresp_msg_result);
         wb_tag   <= head_tag;
      end else if (wb_fire) begin
         wb_state <= ST_EMPTY;
      end
   end

   // A response with nothing outstanding is a divider protocol violation.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                       err <= 1'b0;
      else if (divresp_val && q_empty) err <= 1'b1;
   end

endmodule

// File: tb/tb_imuldiv_div_issue_unit.sv
// Bench for imuldiv_div_issue_unit: divider/consumer models plus a
// writeback scoreboard fed at op accept time.
module tb_imuldiv_div_issue_unit;

   localparam int DEPTH = 4;
   localparam int TAGW  = 5;

   logic            clk;
   logic            reset;
   logic            op_val, op_rdy, op_fn, op_sel;
   logic [31:0]     op_a, op_b;
   logic [TAGW-1:0] op_tag;
   logic            divreq_msg_fn;
   logic [31:0]     divreq_msg_a, divreq_msg_b;
   logic            divreq_val, divreq_rdy;
   logic [63:0]     divresp_msg_result;
   logic            divresp_val, divresp_rdy;
   logic            wb_val, wb_rdy;
   logic [31:0]     wb_data;
   logic [TAGW-1:0] wb_tag;
   logic            err;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int n_req_fire = 0;
   int n_wb = 0;
   int last_resp_edge = -1;

   logic [TAGW+31:0] exp_q [$];
   logic [63:0]      div_q [$];
   logic [TAGW+31:0] sb_e;

   bit rand_mode  = 0;
   bit resp_hold  = 0;
   bit resp_force = 0;

   imuldiv_div_issue_unit #(.DEPTH(DEPTH), .TAGW(TAGW)) dut (
      .clk(clk), .reset(reset),
      .op_val(op_val), .op_rdy(op_rdy), .op_fn(op_fn), .op_sel(op_sel),
      .op_a(op_a), .op_b(op_b), .op_tag(op_tag),
      .divreq_msg_fn(divreq_msg_fn), .divreq_msg_a(divreq_msg_a), .divreq_msg_b(divreq_msg_b),
      .divreq_val(divreq_val), .divreq_rdy(divreq_rdy),
      .divresp_msg_result(divresp_msg_result), .divresp_val(divresp_val), .divresp_rdy(divresp_rdy),
      .wb_val(wb_val), .wb_rdy(wb_rdy), .wb_data(wb_data), .wb_tag(wb_tag),
      .err(err)
   );

   // clock / reset
   initial clk = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   function automatic logic [63:0] ref_result(input logic fn, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] q, r;
      if (fn) begin
         q = a / b;
         r = a % b;
      end else begin
         q = $signed(a) / $signed(b);
         r = $signed(a) % $signed(b);
      end
      return {r, q};
   endfunction

   function automatic logic [31:0] exp_data(input logic fn, input logic sel, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] r;
      r = ref_result(fn, a, b);
      return sel ? r[63:32] : r[31:0];
   endfunction

   // monitor + scoreboard, sampled mid-cycle
   always @(negedge clk) begin
      if (!reset) begin
         if (op_val && op_rdy) exp_q.push_back({op_tag, exp_data(op_fn, op_sel, op_a, op_b)});
         if (divreq_val && divreq_rdy) begin
            n_req_fire++;
            div_q.push_back(ref_result(divreq_msg_fn, divreq_msg_a, divreq_msg_b));
         end
         if (divresp_val && divresp_rdy) begin
            last_resp_edge = cyc + 1;
            if (div_q.size() > 0) void'(div_q.pop_front());
         end
         if (wb_val && wb_rdy) begin
            n_wb++;
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL sb_unexpected_wb: got tag=%0d data=%h, required no writeback", wb_tag, wb_data);
            end else begin
               sb_e = exp_q.pop_front();
               if ({wb_tag, wb_data} !== sb_e) begin
                  bad++;
                  $display("FAIL sb_wb: got tag=%0d data=%h, required tag=%0d data=%h",
                           wb_tag, wb_data, sb_e[TAGW+31:32], sb_e[31:0]);
               end
            end
         end
      end
   end

   // divider and consumer models
   always @(posedge clk) begin
      #2;
      if (rand_mode) begin
         divreq_rdy = ($urandom_range(0, 3) != 0);
         wb_rdy     = ($urandom_range(0, 2) != 0);
      end
      if (resp_force) begin
         divresp_val = 1'b1;
         divresp_msg_result = '0;
      end else if (div_q.size() > 0 && !resp_hold && (!rand_mode || $urandom_range(0, 2) != 0)) begin
         divresp_val = 1'b1;
         divresp_msg_result = div_q[0];
      end else begin
         divresp_val = 1'b0;
         divresp_msg_result = '0;
      end
   end

   // driver tasks: called at posedge+2, return at posedge+2 after accept
   task automatic send_op(input logic fn, input logic sel, input logic [31:0] a, input logic [31:0] b,
                          input logic [TAGW-1:0] tag, output bit ok);
      op_val = 1; op_fn = fn; op_sel = sel; op_a = a; op_b = b; op_tag = tag;
      ok = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (op_rdy) begin
            ok = 1;
            break;
         end
      end
      @(posedge clk); #2;
      op_val = 0;
   endtask

   task automatic wait_wb_val(input int max, output bit ok);
      ok = 0;
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         if (wb_val) begin
            ok = 1;
            return;
         end
      end
   endtask

   task automatic wait_drain(input int max, output bit ok);
      ok = 0;
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && div_q.size() == 0 && !wb_val) begin
            ok = 1;
            return;
         end
      end
   endtask

   task automatic test_reset;
      @(negedge clk);
      total++; if (op_rdy !== 1'b1)      begin bad++; $display("FAIL reset_op_rdy: got %b, required 1", op_rdy); end
      total++; if (divreq_val !== 1'b0)  begin bad++; $display("FAIL reset_divreq_val: got %b, required 0", divreq_val); end
      total++; if (wb_val !== 1'b0)      begin bad++; $display("FAIL reset_wb_val: got %b, required 0", wb_val); end
      total++; if (err !== 1'b0)         begin bad++; $display("FAIL reset_err: got %b, required 0", err); end
      total++; if (divresp_rdy !== 1'b0) begin bad++; $display("FAIL reset_divresp_rdy: got %b, required 0", divresp_rdy); end
      @(posedge clk); #2;
      reset = 0;
   endtask

   task automatic test_unsigned_quot;
      bit ok;
      @(posedge clk); #2;
      divreq_rdy = 0; wb_rdy = 0; resp_hold = 0;
      send_op(1'b1, 1'b0, 32'd100, 32'd7, 5'd3, ok);
      total++; if (!ok) begin bad++; $display("FAIL uq_accept: got no accept, required accept"); end
      #1;
      total++;
      if ({divreq_val, divreq_msg_fn, divreq_msg_a, divreq_msg_b} !== {1'b1, 1'b1, 32'd100, 32'd7}) begin
         bad++;
         $display("FAIL uq_divreq: got val=%b fn=%b a=%0d b=%0d, required val=1 fn=1 a=100 b=7",
                  divreq_val, divreq_msg_fn, divreq_msg_a, divreq_msg_b);
      end
      @(posedge clk); #2;
      divreq_rdy = 1;
      wait_wb_val(20, ok);
      total++;
      if (!ok) begin
         bad++; $display("FAIL uq_wb_timeout: got no wb_val, required wb_val");
      end else begin
         total++; if (wb_data !== 32'd14) begin bad++; $display("FAIL uq_wb_data: got %0d, required 14", wb_data); end
         total++; if (wb_tag !== 5'd3)    begin bad++; $display("FAIL uq_wb_tag: got %0d, required 3", wb_tag); end
         total++; if (cyc != last_resp_edge) begin bad++; $display("FAIL uq_wb_latency: got edge %0d, required edge %0d", cyc, last_resp_edge); end
      end
      @(posedge clk); #2; wb_rdy = 1;
      @(posedge clk); #2; wb_rdy = 0;
   endtask

   task automatic test_signed_rem;
      bit ok;
      divreq_rdy = 1; wb_rdy = 0; resp_hold = 0;
      send_op(1'b0, 1'b1, -32'sd7, 32'd2, 5'd9, ok);
      total++; if (!ok) begin bad++; $display("FAIL sr_accept: got no accept, required accept"); end
      wait_wb_val(20, ok);
      total++;
      if (!ok) begin
         bad++; $display("FAIL sr_wb_timeout: got no wb_val, required wb_val");
      end else begin
         total++; if (wb_data !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sr_wb_data: got %h, required ffffffff", wb_data); end
         total++; if (wb_tag !== 5'd9)           begin bad++; $display("FAIL sr_wb_tag: got %0d, required 9", wb_tag); end
      end
      @(posedge clk); #2; wb_rdy = 1;
      @(posedge clk); #2; wb_rdy = 0;
   endtask

   task automatic test_queue_full;
      bit ok, all_ok, seen;
      int base, c0;
      divreq_rdy = 1; resp_hold = 1; wb_rdy = 0;
      base = n_req_fire;
      c0 = cyc;
      all_ok = 1;
      for (int k = 1; k <= 5; k++) begin
         send_op(1'b1, k[0], 32'(50 + k), 32'd3, 5'(10 + k), ok);
         all_ok &= ok;
      end
      total++; if (!all_ok) begin bad++; $display("FAIL qf_accept5: got a refused op, required 5 accepts"); end
      total++; if (cyc - c0 != 5) begin bad++; $display("FAIL qf_back_to_back: got %0d cycles, required 5", cyc - c0); end
      op_val = 1; op_fn = 1; op_sel = 0; op_a = 32'd99; op_b = 32'd4; op_tag = 5'd16;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++; if (op_rdy !== 1'b0)     begin bad++; $display("FAIL qf_op_rdy_6th: got %b, required 0", op_rdy); end
         total++; if (divreq_val !== 1'b0) begin bad++; $display("FAIL qf_divreq_val_5th: got %b, required 0", divreq_val); end
      end
      total++; if (n_req_fire - base != 4) begin bad++; $display("FAIL qf_req_fires: got %0d, required 4", n_req_fire - base); end
      @(posedge clk); #2;
      op_val = 0;
      resp_hold = 0;
      seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (divresp_val && divresp_rdy) seen = 1;
      end
      total++;
      if (!seen) begin
         bad++; $display("FAIL qf_resp_timeout: got no response fire, required one");
      end else begin
         total++; if (divreq_val !== 1'b0) begin bad++; $display("FAIL qf_no_issue_on_pop: got %b, required 0", divreq_val); end
         @(negedge clk);
         total++; if (divreq_val !== 1'b1) begin bad++; $display("FAIL qf_issue_after_pop: got %b, required 1", divreq_val); end
      end
      @(posedge clk); #2;
      wb_rdy = 1;
      wait_drain(100, ok);
      total++; if (!ok) begin bad++; $display("FAIL qf_drain: got %0d pending, required 0", exp_q.size()); end
      total++; if (n_req_fire - base != 5) begin bad++; $display("FAIL qf_req_fires_total: got %0d, required 5", n_req_fire - base); end
      @(posedge clk); #2; wb_rdy = 0;
   endtask

   task automatic test_wb_backpressure;
      bit ok, ok2;
      logic [31:0] d0;
      logic [TAGW-1:0] t0;
      int w0;
      divreq_rdy = 1; resp_hold = 1; wb_rdy = 0;
      w0 = n_wb;
      send_op(1'b1, 1'b0, 32'd200, 32'd9, 5'd20, ok);
      send_op(1'b1, 1'b1, 32'd200, 32'd9, 5'd21, ok2);
      total++; if (!(ok && ok2)) begin bad++; $display("FAIL bp_accept: got a refused op, required 2 accepts"); end
      repeat (3) @(posedge clk);
      #2;
      resp_hold = 0;
      wait_wb_val(20, ok);
      total++;
      if (!ok) begin
         bad++; $display("FAIL bp_wb_timeout: got no wb_val, required wb_val");
      end else begin
         d0 = wb_data; t0 = wb_tag;
         total++; if ({t0, d0} !== {5'd20, 32'd22}) begin bad++; $display("FAIL bp_first: got tag=%0d data=%0d, required tag=20 data=22", t0, d0); end
         for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++; if (divresp_rdy !== 1'b0) begin bad++; $display("FAIL bp_divresp_rdy: got %b, required 0", divresp_rdy); end
            total++;
            if ({wb_val, wb_tag, wb_data} !== {1'b1, t0, d0}) begin
               bad++; $display("FAIL bp_hold: got val=%b tag=%0d data=%0d, required val=1 tag=%0d data=%0d", wb_val, wb_tag, wb_data, t0, d0);
            end
         end
         total++; if (div_q.size() != 1) begin bad++; $display("FAIL bp_second_pending: got %0d, required 1", div_q.size()); end
      end
      @(posedge clk); #2;
      wb_rdy = 1;
      wait_drain(30, ok);
      total++; if (!ok) begin bad++; $display("FAIL bp_drain: got %0d pending, required 0", exp_q.size()); end
      total++; if (n_wb - w0 != 2) begin bad++; $display("FAIL bp_wb_count: got %0d, required 2", n_wb - w0); end
      @(posedge clk); #2; wb_rdy = 0;
   endtask

   task automatic test_order_wrap;
      bit ok, all_ok;
      int w0, r0;
      w0 = n_wb; r0 = n_req_fire;
      all_ok = 1;
      rand_mode = 1; resp_hold = 0;
      for (int k = 1; k <= 10; k++) begin
         send_op(logic'($urandom_range(0, 1)), k[0], $urandom, 32'($urandom_range(1, 1000)), 5'(k), ok);
         all_ok &= ok;
      end
      total++; if (!all_ok) begin bad++; $display("FAIL ow_accept: got a timed-out op, required 10 accepts"); end
      wait_drain(500, ok);
      total++; if (!ok) begin bad++; $display("FAIL ow_drain: got %0d pending, required 0", exp_q.size()); end
      total++; if (n_wb - w0 != 10) begin bad++; $display("FAIL ow_wb_count: got %0d, required 10", n_wb - w0); end
      total++; if (n_req_fire - r0 != 10) begin bad++; $display("FAIL ow_req_count: got %0d, required 10", n_req_fire - r0); end
      rand_mode = 0;
      @(posedge clk); #3;
      divreq_rdy = 0; wb_rdy = 0;
      @(posedge clk); #2;
   endtask

   task automatic test_error_reset;
      bit ok, seen;
      divreq_rdy = 1; wb_rdy = 0; resp_hold = 0;
      send_op(1'b1, 1'b0, 32'd9, 32'd3, 5'd5, ok);
      wait_wb_val(20, ok);
      total++; if (!ok) begin bad++; $display("FAIL er_wb_setup: got no wb_val, required wb_val"); end
      @(posedge clk); #2;
      divreq_rdy = 0;
      send_op(1'b1, 1'b0, 32'd8, 32'd2, 5'd6, ok);
      resp_force = 1;
      seen = 0;
      for (int i = 0; i < 4 && !seen; i++) begin
         @(negedge clk);
         if (divresp_val) seen = 1;
      end
      total++; if (divresp_rdy !== 1'b0) begin bad++; $display("FAIL er_divresp_rdy: got %b, required 0", divresp_rdy); end
      @(negedge clk);
      total++; if (err !== 1'b1) begin bad++; $display("FAIL er_err_set: got %b, required 1", err); end
      total++;
      if ({divreq_val, wb_val} !== 2'b11) begin
         bad++; $display("FAIL er_pre_reset_valid: got divreq_val=%b wb_val=%b, required 1 1", divreq_val, wb_val);
      end
      #3;
      reset = 1;
      #1;
      total++; if (err !== 1'b0)        begin bad++; $display("FAIL er_async_err: got %b, required 0", err); end
      total++; if (wb_val !== 1'b0)     begin bad++; $display("FAIL er_async_wb_val: got %b, required 0", wb_val); end
      total++; if (divreq_val !== 1'b0) begin bad++; $display("FAIL er_async_divreq_val: got %b, required 0", divreq_val); end
      resp_force = 0;
      exp_q.delete();
      div_q.delete();
      @(posedge clk); #2;
      reset = 0;
      #1;
      total++; if (op_rdy !== 1'b1) begin bad++; $display("FAIL er_op_rdy_after: got %b, required 1", op_rdy); end
      @(negedge clk);
      total++; if (err !== 1'b0) begin bad++; $display("FAIL er_err_after: got %b, required 0", err); end
   endtask

   initial begin
      reset = 1;
      op_val = 0; op_fn = 0; op_sel = 0; op_a = '0; op_b = '0; op_tag = '0;
      divreq_rdy = 0; wb_rdy = 0;
      divresp_val = 0; divresp_msg_result = '0;
      repeat (3) @(posedge clk);
      test_reset();
      test_unsigned_quot();
      test_signed_rem();
      test_queue_full();
      test_wb_backpressure();
      test_order_wrap();
      test_error_reset();
      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/imuldiv_div_issue_unit.md
Name: imuldiv_div_issue_unit

Overview:
Requester-side client of the iterative divider's divreq/divresp val/rdy interface, placed between the PARC X stage and the div unit. It registers each divide operation and issues it as a divreq. It tracks the destination tag and the quotient/remainder select of every outstanding request in an in-order queue. It returns one 32-bit writeback per response, in request order.

Parameters:
DEPTH, 4, maximum outstanding divreqs (tag queue entries); power of two, at least 2
TAGW, 5, destination tag width (register specifier)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
op_val  in  1  operation valid from pipeline
op_rdy  out  1  operation accepted when op_val && op_rdy
op_fn  in  1  0 = signed, 1 = unsigned (same encoding as divreq_msg_fn)
op_sel  in  1  0 = quotient, 1 = remainder
op_a  in  32  dividend
op_b  in  32  divisor
op_tag  in  TAGW  destination tag
divreq_msg_fn  out  1  to divider
divreq_msg_a  out  32  to divider
divreq_msg_b  out  32  to divider
divreq_val  out  1  request valid
divreq_rdy  in  1  divider ready
divresp_msg_result  in  64  {remainder[63:32], quotient[31:0]}
divresp_val  in  1  response valid
divresp_rdy  out  1  response accepted
wb_val  out  1  writeback valid
wb_rdy  in  1  writeback consumer ready
wb_data  out  32  selected quotient or remainder
wb_tag  out  TAGW  destination tag
err  out  1  sticky protocol error

Behaviour:
- Reset (asynchronous, active-high): req_full=0, wb_full=0, queue pointers=0, count=0, err=0; divreq_val=0, wb_val=0; data registers cleared to 0. Reset mid-operation drops all in-flight state. The divider shares this reset.
- Request register (states EMPTY/FULL):
  - Captures {fn,a,b,sel,tag} on op fire.
  - op_rdy = !req_full || req_fire.
  - Back-to-back accept is allowed when the register drains in the same cycle.
- Issue:
  - divreq_val = req_full && !q_full.
  - req_fire = divreq_val && divreq_rdy.
  - On req_fire, push {sel,tag} into the queue and clear req_full, unless a new op is captured in the same cycle.
  - Outputs are driven from the register; latency from op fire to divreq_val is 1 cycle.
- Tag queue:
  - Circular buffer of DEPTH entries; head and tail wrap modulo DEPTH.
  - count is clog2(DEPTH)+1 bits.
  - q_full when count==DEPTH: the push is blocked even if a pop occurs in the same cycle.
  - Simultaneous push and pop when not full leaves count unchanged.
- Response:
  - divresp_rdy = !q_empty && (!wb_full || wb_fire).
  - On resp fire, pop the queue head and load the writeback register:
    - wb_data = sel ? result[63:32] : result[31:0]
    - wb_tag = head tag
  - Latency from resp fire to wb_val is 1 cycle.
- Writeback register (EMPTY/FULL):
  - wb_val = wb_full.
  - wb_fire = wb_val && wb_rdy.
  - Data and tag are held stable while wb_val && !wb_rdy.
- Error: divresp_val while q_empty sets err=1 (sticky until reset). The response is not accepted (divresp_rdy=0).
- Responses are delivered strictly in issue order; the divider is required to be in-order.
- Throughput: one op per cycle, given a responsive divider and consumer.

Decomposition:
- Shared package/header holds:
  - fn encodings, reused from the existing DivReqMsg definitions
  - select constants SEL_QUOT=0 and SEL_REM=1
  - the result field slices for quotient [31:0] and remainder [63:32]
- One sub-module, imuldiv_DivTagQueue: a parameterised DEPTH×(1+TAGW) in-order FIFO with push/pop/full/empty. Async reset; wrap-around pointers.
- Control and the two stage registers stay in the top level.

Test Plan:
- Unsigned quotient:
  - Stimulus: op fn=1 sel=0 a=100 b=7 tag=3.
  - Required: divreq a=100 b=7 one cycle after accept.
  - Stimulus: drive resp {32'd2, 32'd14}.
  - Required: wb_data=14, wb_tag=3 one cycle later.
- Signed remainder:
  - Stimulus: fn=0 sel=1 a=-7 b=2 tag=9, then resp {32'hFFFFFFFF, 32'hFFFFFFFD}.
  - Required: wb_data=32'hFFFFFFFF, wb_tag=9.
- Queue full (DEPTH=4):
  - Stimulus: divreq_rdy=1, divresp_val=0, issue 6 ops.
  - Required: exactly 4 req fires; divreq_val=0 while the 5th sits in the request register; op_rdy=0 for the 6th.
  - Stimulus: one resp.
  - Required: the 5th issues the cycle after the pop.
- Writeback backpressure:
  - Stimulus: wb_rdy=0 with 2 responses pending.
  - Required: the first response is accepted; divresp_rdy=0 afterwards; wb_data/wb_tag stay stable.
  - Stimulus: raise wb_rdy.
  - Required: both drain in order.
- Ordering and wrap-around:
  - Stimulus: 10 ops, tags 1..10, alternating sel, with random divider/consumer stalls.
  - Required: wb tags come out 1..10 and each wb_data matches its sel.
- Error and reset:
  - Stimulus: divresp_val=1 with the queue empty.
  - Required: err=1 and divresp_rdy=0.
  - Stimulus: assert reset mid-stream, asynchronously between clock edges.
  - Required: err, wb_val and divreq_val drop to 0 immediately; op_rdy=1 after release.
